// File: rtl/serial_row_loader.sv
// ---------------------------------------------------------------------------
// serial_row_loader
//
// Serial-to-row front end for the SGD regression core. One or more LSB-first
// serial lanes are deserialised into WORD_W-bit words; (feat+1) words form a
// row, and every completed row is written once to the training-data memory
// at its row index, for rows 0..data_points.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   RST          synchronous reset, active low
//   START        one-cycle load request, honoured only when not loading
//   feat         highest word index per row (captured at START)
//   data_points  index of the last row (captured at START)
//   S_IN         serial data; lane k carries bit (beat*LANES + k) of a word
//   S_VALID      S_IN qualifier
//   wr_en        one-cycle row write strobe
//   wr_addr      row index of the write (held until the next write)
//   wr_data      assembled row, word j at [j*WORD_W +: WORD_W] (held)
//   busy         high while loading
//   done         high from the final row write until the next START/reset
//   err          sticky protocol error (stray S_VALID or bad feat at START)
// ---------------------------------------------------------------------------
module serial_row_loader #(
    parameter int WORD_W       = 16,
    parameter int MAX_FEATURES = 15,
    parameter int FEAT_W       = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int LANES        = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 START,
    input  logic [FEAT_W-1:0]                    feat,
    input  logic [ADDR_WIDTH-1:0]                data_points,
    input  logic [LANES-1:0]                     S_IN,
    input  logic                                 S_VALID,
    output logic                                 wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic [WORD_W*(MAX_FEATURES+1)-1:0]   wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int ROW_W = WORD_W * (MAX_FEATURES + 1);
    localparam int BEATS = WORD_W / LANES;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured load parameters
    logic [FEAT_W-1:0]     feat_q;
    logic [ADDR_WIDTH-1:0] last_row_q;

    // Datapath state
    logic [ADDR_WIDTH-1:0] row_cnt;
    logic [BC_W-1:0]       beat_cnt;
    logic [FEAT_W-1:0]     word_idx;
    logic [WORD_W-1:0]     word_sr;
    logic [WORD_W-1:0]     word_nxt;
    logic [ROW_W-1:0]      row_q;
    logic [ROW_W-1:0]      row_merged;

    // Decodes
    logic feat_ok;
    logic start_go;
    logic start_bad;
    logic stray_valid;
    logic beat_en;
    logic word_done;
    logic row_done;
    logic last_row;

    assign feat_ok = (int'(feat) <= MAX_FEATURES);

    // Word shifter input: new lanes enter at the top, so after BEATS beats the
    // first beat has travelled down to bits [LANES-1:0] (LSB first).
    generate
        if (LANES == WORD_W) begin : g_full_lane
            assign word_nxt = S_IN;
        end else begin : g_shift
            assign word_nxt = {S_IN, word_sr[WORD_W-1:LANES]};
        end
    endgenerate

    assign word_done = beat_en && (beat_cnt == LAST_BEAT);
    assign row_done  = word_done && (word_idx == '0);
    assign last_row  = row_done && (row_cnt == last_row_q);

    // Row register with the word being completed this cycle merged into its
    // slot; this is what gets written when word 0 completes.
    always_comb begin
        row_merged = row_q;
        for (int unsigned j = 0; j <= MAX_FEATURES; j++) begin
            if (32'(word_idx) == j) begin
                row_merged[j*WORD_W +: WORD_W] = word_nxt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_go) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (last_row) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and per-state decodes
    // -----------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        start_go    = 1'b0;
        start_bad   = 1'b0;
        stray_valid = 1'b0;
        beat_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done        = (state == DONE);
                start_go    = START && feat_ok;
                start_bad   = START && !feat_ok;
                stray_valid = S_VALID;
            end
            LOAD: begin
                busy    = 1'b1;
                beat_en = S_VALID;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: deserialiser, row assembly and write port
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            feat_q     <= '0;
            last_row_q <= '0;
            row_cnt    <= '0;
            beat_cnt   <= '0;
            word_idx   <= '0;
            word_sr    <= '0;
            row_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_go) begin
                feat_q     <= feat;
                last_row_q <= data_points;
                row_cnt    <= '0;
                beat_cnt   <= '0;
                word_idx   <= feat;
                word_sr    <= '0;
                row_q      <= '0;
            end else if (beat_en) begin
                word_sr <= word_nxt;
                if (word_done) begin
                    beat_cnt <= '0;
                    if (row_done) begin
                        // Row leaves for memory and the next row starts empty
                        // in the same cycle, so back-to-back beats never stall.
                        wr_en    <= 1'b1;
                        wr_addr  <= row_cnt;
                        wr_data  <= row_merged;
                        row_q    <= '0;
                        word_idx <= feat_q;
                        if (!last_row) begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end else begin
                        row_q    <= row_merged;
                        word_idx <= word_idx - 1'b1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky error: set wins over a same-cycle valid START.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            err <= 1'b0;
        end else if (stray_valid || start_bad) begin
            err <= 1'b1;
        end else if (start_go) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_row_loader.sv
module tb_serial_row_loader;
    timeunit 1ns;
    timeprecision 1ps;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge CLK) cyc++;

    // ---------------- DUT A: defaults (LANES=1, MAX_FEATURES=15) ----------
    logic         a_rst, a_start, a_s_valid;
    logic [3:0]   a_feat;
    logic [11:0]  a_dp;
    logic [0:0]   a_s_in;
    logic         a_wr_en, a_busy, a_done, a_err;
    logic [11:0]  a_wr_addr;
    logic [255:0] a_wr_data;

    serial_row_loader dut_a (
        .CLK(CLK), .RST(a_rst), .START(a_start), .feat(a_feat),
        .data_points(a_dp), .S_IN(a_s_in), .S_VALID(a_s_valid),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    // ---------------- DUT B: LANES=4 ---------------------------------------
    logic         rst, b_start, b_s_valid;
    logic [3:0]   b_feat;
    logic [11:0]  b_dp;
    logic [3:0]   b_s_in;
    logic         b_wr_en, b_busy, b_done, b_err;
    logic [11:0]  b_wr_addr;
    logic [255:0] b_wr_data;

    serial_row_loader #(.LANES(4)) dut_b (
        .CLK(CLK), .RST(rst), .START(b_start), .feat(b_feat),
        .data_points(b_dp), .S_IN(b_s_in), .S_VALID(b_s_valid),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    // ---------------- DUT C: MAX_FEATURES=7 --------------------------------
    logic         c_start, c_s_valid;
    logic [3:0]   c_feat;
    logic [11:0]  c_dp;
    logic [0:0]   c_s_in;
    logic         c_wr_en, c_busy, c_done, c_err;
    logic [11:0]  c_wr_addr;
    logic [127:0] c_wr_data;

    serial_row_loader #(.MAX_FEATURES(7)) dut_c (
        .CLK(CLK), .RST(rst), .START(c_start), .feat(c_feat),
        .data_points(c_dp), .S_IN(c_s_in), .S_VALID(c_s_valid),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .busy(c_busy), .done(c_done), .err(c_err)
    );

    // ---------------- reference model / scoreboard ------------------------
    typedef struct {
        logic [11:0]  addr;
        logic [255:0] data;
    } wr_t;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    wr_t         ea, eb;
    logic [15:0] row_w [16];
    int          a_nwr  = 0;
    int          b_nwr  = 0;
    int          b_last = -1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row as the memory should see it: words 0..f in their slots, zero above.
    function automatic logic [255:0] model_row(input int f);
        logic [255:0] r = '0;
        for (int j = 0; j <= f; j++) r[j*16 +: 16] = row_w[j];
        return r;
    endfunction

    task automatic new_row();
        for (int j = 0; j < 16; j++) row_w[j] = 16'($urandom);
    endtask

    task automatic expect_a(input int addr, input int f);
        wr_t w;
        w.addr = 12'(addr);
        w.data = model_row(f);
        exp_a.push_back(w);
    endtask

    task automatic expect_b(input int addr, input int f);
        wr_t w;
        w.addr = 12'(addr);
        w.data = model_row(f);
        exp_b.push_back(w);
    endtask

    always @(negedge CLK) begin
        if (a_wr_en) begin
            a_nwr++;
            if (exp_a.size() == 0) begin
                chk("a_unexpected_wr", a_wr_en, 1'b0);
            end else begin
                ea = exp_a.pop_front();
                chk("a_wr_addr", a_wr_addr, ea.addr);
                chk("a_wr_data", a_wr_data, ea.data);
            end
        end
    end

    always @(negedge CLK) begin
        if (b_wr_en) begin
            b_nwr++;
            if (b_last >= 0) chk("b_spacing", cyc - b_last, 60);
            b_last = cyc;
            if (exp_b.size() == 0) begin
                chk("b_unexpected_wr", b_wr_en, 1'b0);
            end else begin
                eb = exp_b.pop_front();
                chk("b_wr_addr", b_wr_addr, eb.addr);
                chk("b_wr_data", b_wr_data, eb.data);
            end
        end
    end

    always @(negedge CLK) begin
        if (c_wr_en) chk("c_unexpected_wr", c_wr_en, 1'b0);
    end

    // ---------------- stimulus helpers -------------------------------------
    // Inputs change on the falling edge; the DUT samples them on the next
    // rising edge and results are looked at on the following falling edge.
    task automatic a_start_load(input int f, input int dp);
        a_feat  = 4'(f);
        a_dp    = 12'(dp);
        a_start = 1'b1;
        @(negedge CLK);
        a_start = 1'b0;
    endtask

    task automatic a_send_word(input logic [15:0] w, input bit gap, input bit last,
                               input bit pulse_start);
        for (int b = 0; b < 16; b++) begin
            a_s_valid = 1'b1;
            a_s_in    = w[b];
            if (pulse_start && b == 0) begin
                a_start = 1'b1;
                a_feat  = 4'd0;
            end
            @(negedge CLK);
            a_start = 1'b0;
            if (gap && !(last && b == 15)) begin
                a_s_valid = 1'b0;
                a_s_in    = '0;
                @(negedge CLK);
            end
        end
    endtask

    task automatic a_send_row(input int f, input bit gap, input bit pulse_start);
        for (int j = f; j >= 0; j--) a_send_word(row_w[j], gap, j == 0, pulse_start && j == f);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b0; rst = 1'b0;
        a_start = 1'b0; a_s_valid = 1'b0; a_feat = '0; a_dp = '0; a_s_in = '0;
        b_start = 1'b0; b_s_valid = 1'b0; b_feat = '0; b_dp = '0; b_s_in = '0;
        c_start = 1'b0; c_s_valid = 1'b0; c_feat = '0; c_dp = '0; c_s_in = '0;
        for (int j = 0; j < 16; j++) row_w[j] = '0;
        repeat (2) @(negedge CLK);

        // Reset values
        chk("rst_wr_en", a_wr_en, 1'b0);
        chk("rst_wr_addr", a_wr_addr, 12'd0);
        chk("rst_wr_data", a_wr_data, '0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_b_busy", b_busy, 1'b0);
        a_rst = 1'b1;
        rst   = 1'b1;
        @(negedge CLK);

        // T1: feat=1, data_points=0, continuous beats, 0xBEEF then 0x1234
        a_start_load(1, 0);
        chk("t1_busy_rise", a_busy, 1'b1);
        row_w[1] = 16'hBEEF;
        row_w[0] = 16'h1234;
        expect_a(0, 1);
        a_send_row(1, 1'b0, 1'b0);
        chk("t1_wr_en", a_wr_en, 1'b1);
        chk("t1_wr_data", a_wr_data, 256'hBEEF1234);
        chk("t1_wr_addr", a_wr_addr, 12'd0);
        chk("t1_done", a_done, 1'b1);
        chk("t1_busy_fall", a_busy, 1'b0);
        a_s_valid = 1'b0;
        @(negedge CLK);
        chk("t1_wr_en_one_cycle", a_wr_en, 1'b0);
        chk("t1_data_hold", a_wr_data, 256'hBEEF1234);
        chk("t1_done_hold", a_done, 1'b1);
        chk("t1_no_err", a_err, 1'b0);

        // T2: same row with S_VALID low on every other cycle
        a_start_load(1, 0);
        chk("t2_done_clear", a_done, 1'b0);
        chk("t2_busy", a_busy, 1'b1);
        expect_a(0, 1);
        a_send_row(1, 1'b1, 1'b0);
        chk("t2_wr_en", a_wr_en, 1'b1);
        chk("t2_wr_data", a_wr_data, 256'hBEEF1234);
        chk("t2_done", a_done, 1'b1);
        chk("t2_no_err", a_err, 1'b0);
        a_s_valid = 1'b0;
        @(negedge CLK);

        // T3: reset at beat 10 of row 3
        a_start_load(3, 5);
        for (int r = 0; r < 3; r++) begin
            new_row();
            expect_a(r, 3);
            a_send_row(3, 1'b0, 1'b0);
        end
        new_row();
        for (int b = 0; b < 10; b++) begin
            a_s_valid = 1'b1;
            a_s_in    = row_w[3][b];
            @(negedge CLK);
        end
        a_s_valid = 1'b0;
        a_rst     = 1'b0;
        @(negedge CLK);
        chk("t3_rst_wr_en", a_wr_en, 1'b0);
        chk("t3_rst_wr_addr", a_wr_addr, 12'd0);
        chk("t3_rst_wr_data", a_wr_data, '0);
        chk("t3_rst_busy", a_busy, 1'b0);
        chk("t3_rst_done", a_done, 1'b0);
        chk("t3_rst_err", a_err, 1'b0);
        a_rst = 1'b1;
        @(negedge CLK);

        // T4: stray S_VALID in IDLE, error clear on START, START mid-load
        a_s_valid = 1'b1;
        a_s_in    = 1'b1;
        @(negedge CLK);
        a_s_valid = 1'b0;
        chk("t4_err_set", a_err, 1'b1);
        chk("t4_no_wr", a_wr_en, 1'b0);
        @(negedge CLK);
        chk("t4_err_sticky", a_err, 1'b1);
        a_start_load(3, 1);
        chk("t4_err_clear", a_err, 1'b0);
        chk("t4_busy", a_busy, 1'b1);
        new_row();
        expect_a(0, 3);
        a_send_row(3, 1'b0, 1'b1);
        new_row();
        expect_a(1, 3);
        a_send_row(3, 1'b0, 1'b0);
        chk("t4_final_wr_en", a_wr_en, 1'b1);
        chk("t4_final_addr", a_wr_addr, 12'd1);
        chk("t4_done", a_done, 1'b1);
        chk("t4_busy_fall", a_busy, 1'b0);
        chk("t4_err_after_midstart", a_err, 1'b0);
        a_s_valid = 1'b0;
        @(negedge CLK);
        chk("a_total_writes", a_nwr, 7);
        chk("a_queue_empty", exp_a.size(), 0);

        // T5: LANES=4, feat=14, 100 rows back to back
        b_feat  = 4'd14;
        b_dp    = 12'd99;
        b_start = 1'b1;
        @(negedge CLK);
        b_start = 1'b0;
        chk("t5_busy", b_busy, 1'b1);
        for (int r = 0; r < 100; r++) begin
            new_row();
            expect_b(r, 14);
            for (int j = 14; j >= 0; j--) begin
                for (int bt = 0; bt < 4; bt++) begin
                    b_s_valid = 1'b1;
                    b_s_in    = row_w[j][bt*4 +: 4];
                    @(negedge CLK);
                end
            end
        end
        chk("t5_final_wr_en", b_wr_en, 1'b1);
        chk("t5_final_addr", b_wr_addr, 12'd99);
        chk("t5_done", b_done, 1'b1);
        chk("t5_busy_fall", b_busy, 1'b0);
        b_s_valid = 1'b0;
        @(negedge CLK);
        chk("t5_total_writes", b_nwr, 100);
        chk("t5_queue_empty", exp_b.size(), 0);
        chk("t5_no_err", b_err, 1'b0);

        // T6: MAX_FEATURES=7, feat=9 is rejected
        c_feat  = 4'd9;
        c_dp    = 12'd3;
        c_start = 1'b1;
        @(negedge CLK);
        c_start = 1'b0;
        chk("t6_err", c_err, 1'b1);
        chk("t6_busy", c_busy, 1'b0);
        chk("t6_done", c_done, 1'b0);
        repeat (3) @(negedge CLK);
        chk("t6_stays_idle", c_busy, 1'b0);
        chk("t6_err_sticky", c_err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_row_loader.md
# serial_row_loader

Parametrised serial-to-row front end for the SGD regression core. Deserialises one or more LSB-first serial lanes into WORD_W-bit words, packs (feat+1) words per data point into one row, and issues one write per row to the training-data memory for rows 0..data_points. It generalises the single-bit serial input path with configurable lane count, word width, a valid qualifier, completion and error reporting.

## Interface
- WORD_W, 16, bits per word (feature or y value)
- MAX_FEATURES, 15, maximum feature index; row holds MAX_FEATURES+1 words
- FEAT_W, 4, width of feat port
- ADDR_WIDTH, 12, row address / data-point count width
- LANES, 1, parallel serial lanes; must divide WORD_W (1,2,4,8,16)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; synchronous, active-low
- START  in  1  one-cycle load request; sampled only in IDLE/DONE
- feat  in  FEAT_W  highest word index per row (row = feat+1 words); captured at START
- data_points  in  ADDR_WIDTH  last row index (rows 0..data_points); captured at START
- S_IN  in  LANES  serial data; lane k carries bit (beat*LANES + k) of current word
- S_VALID  in  1  S_IN valid this cycle
- wr_en  out  1  one-cycle row write strobe
- wr_addr  out  ADDR_WIDTH  row index of write
- wr_data  out  WORD_W*(MAX_FEATURES+1)  assembled row; word j at bits [j*WORD_W +: WORD_W]
- busy  out  1  high in LOAD
- done  out  1  high from final row write until next START or reset
- err  out  1  sticky protocol error

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE/DONE + START: if feat <= MAX_FEATURES -> LOAD; clear done, err, bit/word/row counters, row register. Else stay, set err.
- LOAD: each cycle with S_VALID shifts LANES bits into word shifter, LSB first. WORD_W/LANES valid beats complete one word.
- Word order within row: feat first, down to 0. Completed word with index j stored in slot j. Slots above feat are zero in every written row.
- Completion of word 0: row register (with word 0 merged) loaded into wr_data, wr_addr = row counter, wr_en = 1 next cycle; row register cleared, word index reloads feat, row counter increments. No stall: S_VALID beats for next row are accepted in the same and following cycles.
- Row counter equal to data_points at word-0 completion: final row; LOAD -> DONE, done set with that wr_en, busy drops same cycle.
- S_VALID while not in LOAD: err set, data ignored, no write.
- START while in LOAD: ignored, no error.
- S_VALID low: no shift, counters hold (gaps of any length allowed).
- Row counter never wraps; max rows = 2^ADDR_WIDTH.
- RST low in any state: all state, counters, partial word and row discarded; next cycle outputs at reset values.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0.
- busy rises the cycle after START sampled.
- wr_en high exactly one cycle, the cycle after the edge sampling the last beat of word 0; wr_addr/wr_data hold until next write.
- Minimum row period with continuous S_VALID: (feat+1)*WORD_W/LANES cycles; consecutive wr_en separated by exactly that.
- done and final wr_en rise in the same cycle; busy falls in that cycle.
- err rises the cycle after the offending S_VALID or START; cleared only by valid START or reset.

## Test plan
- LANES=1, feat=1, data_points=0: START, stream 0xBEEF then 0x1234 LSB-first, 32 continuous beats -> single wr_en one cycle after beat 32, wr_addr=0, wr_data[31:0]=0xBEEF1234, rest 0; done=1, busy=0 same cycle.
- Same stimulus with S_VALID low on every other cycle -> identical wr_data/wr_addr, wr_en delayed by 31 cycles; no err.
- LANES=4, feat=14, data_points=99, 100 random rows back-to-back -> 100 wr_en pulses spaced 60 cycles, wr_addr 0..99, each wr_data matches model with slot 15 zero; done with 100th write.
- RST low at beat 10 of row 3 -> next cycle all outputs 0, state IDLE; new START reloads from wr_addr 0 with correct data.
- S_VALID pulse in IDLE -> err=1, no wr_en; START (feat=3) -> err=0 next cycle; START mid-LOAD -> ignored, row sequence unchanged.
- MAX_FEATURES=7, feat=9, START -> err=1, stays IDLE, busy=0, no writes.
